// File: rtl/rgb_mixer_pkg.sv
// Shared constants and types for the three-channel RGB encoder/PWM mixer.
package rgb_mixer_pkg;

  localparam int unsigned WIDTH_DEF        = 8;
  localparam int unsigned DEBOUNCE_LEN_DEF = 8;
  localparam int unsigned NUM_CH           = 3;

  typedef logic [WIDTH_DEF-1:0] level_t;

endpackage

// File: rtl/rgb_channel.sv
// One mixer channel: encoder synchronizers, optional debouncers, detent decoder,
// level register and PWM comparator. Debouncers exist only with RGB_MIXER_DEBOUNCE_EN.
module rgb_channel
  import rgb_mixer_pkg::*;
#(
  parameter int unsigned WIDTH        = WIDTH_DEF,
  parameter int unsigned DEBOUNCE_LEN = DEBOUNCE_LEN_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enc_a_i,
  input  logic             enc_b_i,
  input  logic [WIDTH-1:0] pwm_cnt_i,
  output logic             pwm_o
);

  if (DEBOUNCE_LEN < 2) begin : g_bad_debounce_len
    $error("rgb_channel: DEBOUNCE_LEN must be at least 2");
  end

  logic [1:0]       a_sync_q, b_sync_q;
  logic             a_dec, b_dec;
  logic             a_prev_q;
  logic [WIDTH-1:0] level_q, level_d;
  logic             pwm_q;

  // Two-flop synchronizers for the asynchronous encoder phases.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_sync_q <= 2'b00;
      b_sync_q <= 2'b00;
    end else begin
      a_sync_q <= {a_sync_q[0], enc_a_i};
      b_sync_q <= {b_sync_q[0], enc_b_i};
    end
  end

`ifdef RGB_MIXER_DEBOUNCE_EN
  logic [DEBOUNCE_LEN-1:0] a_sr_q, b_sr_q;
  logic                    a_deb_q, b_deb_q;

  // A line only flips once DEBOUNCE_LEN identical samples have been seen.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      a_deb_q <= 1'b0;
      b_deb_q <= 1'b0;
    end else begin
      a_sr_q <= {a_sr_q[DEBOUNCE_LEN-2:0], a_sync_q[1]};
      b_sr_q <= {b_sr_q[DEBOUNCE_LEN-2:0], b_sync_q[1]};
      if (&a_sr_q)        a_deb_q <= 1'b1;
      else if (~|a_sr_q)  a_deb_q <= 1'b0;
      if (&b_sr_q)        b_deb_q <= 1'b1;
      else if (~|b_sr_q)  b_deb_q <= 1'b0;
    end
  end

  assign a_dec = a_deb_q;
  assign b_dec = b_deb_q;
`else
  assign a_dec = a_sync_q[1];
  assign b_dec = b_sync_q[1];
`endif

  // Only the rising edge of a counts, so each detent gives exactly one step.
  always_comb begin
    level_d = level_q;
    if (a_dec && !a_prev_q) begin
      level_d = b_dec ? level_q - WIDTH'(1) : level_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_prev_q <= 1'b0;
      level_q  <= '0;
      pwm_q    <= 1'b0;
    end else begin
      a_prev_q <= a_dec;
      level_q  <= level_d;
      pwm_q    <= (pwm_cnt_i < level_q);
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/rgb_mixer.sv
// Three-channel RGB mixer top: shared free-running PWM counter plus one rgb_channel
// per colour. Build option RGB_MIXER_DEBOUNCE_EN enables the encoder debouncers.
module rgb_mixer
  import rgb_mixer_pkg::*;
#(
  parameter int unsigned WIDTH        = WIDTH_DEF,
  parameter int unsigned DEBOUNCE_LEN = DEBOUNCE_LEN_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic enc0_a,
  input  logic enc0_b,
  input  logic enc1_a,
  input  logic enc1_b,
  input  logic enc2_a,
  input  logic enc2_b,
  output logic pwm0,
  output logic pwm1,
  output logic pwm2
);

  logic [WIDTH-1:0]  cnt_q;
  logic [NUM_CH-1:0] enc_a, enc_b, pwm;

  // One counter keeps every channel's PWM period phase-aligned.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_q + WIDTH'(1);
  end

  assign enc_a = {enc2_a, enc1_a, enc0_a};
  assign enc_b = {enc2_b, enc1_b, enc0_b};

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    rgb_channel #(
      .WIDTH        (WIDTH),
      .DEBOUNCE_LEN (DEBOUNCE_LEN)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .enc_a_i   (enc_a[i]),
      .enc_b_i   (enc_b[i]),
      .pwm_cnt_i (cnt_q),
      .pwm_o     (pwm[i])
    );
  end

  assign pwm0 = pwm[0];
  assign pwm1 = pwm[1];
  assign pwm2 = pwm[2];

endmodule

// File: tb/tb_rgb_mixer.sv
// Directed self-checking bench for rgb_mixer; expectations follow the active
// RGB_MIXER_DEBOUNCE_EN build option.
module tb_rgb_mixer;
  import rgb_mixer_pkg::*;

`ifdef RGB_MIXER_DEBOUNCE_EN
  localparam int LAT    = 12;
  localparam bit DEB_ON = 1'b1;
`else
  localparam int LAT    = 3;
  localparam bit DEB_ON = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic [2:0] ea, eb;
  logic       pwm0, pwm1, pwm2;
  level_t     lvl0, lvl1, lvl2;

  int n_checks = 0;
  int n_pass   = 0;

  rgb_mixer dut (
    .clk    (clk),
    .reset  (reset),
    .enc0_a (ea[0]),
    .enc0_b (eb[0]),
    .enc1_a (ea[1]),
    .enc1_b (eb[1]),
    .enc2_a (ea[2]),
    .enc2_b (eb[2]),
    .pwm0   (pwm0),
    .pwm1   (pwm1),
    .pwm2   (pwm2)
  );

  assign lvl0 = dut.g_ch[0].u_ch.level_q;
  assign lvl1 = dut.g_ch[1].u_ch.level_q;
  assign lvl2 = dut.g_ch[2].u_ch.level_q;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n edges, then settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    ea = 3'b000;
    eb = 3'b000;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  // Full quadrature cycle: cw leads with a (a rises while b=0), ccw leads with b.
  task automatic detent(input logic [2:0] mask, input bit ccw);
    if (ccw) eb = eb | mask; else ea = ea | mask;
    tick(20);
    if (ccw) ea = ea | mask; else eb = eb | mask;
    tick(20);
    if (ccw) eb = eb & ~mask; else ea = ea & ~mask;
    tick(20);
    if (ccw) ea = ea & ~mask; else eb = eb & ~mask;
    tick(20);
  endtask

  task automatic measure(input int n, output int c0, output int c1, output int c2,
                         output int unaligned);
    c0 = 0; c1 = 0; c2 = 0; unaligned = 0;
    for (int i = 0; i < n; i++) begin
      tick(1);
      c0 += int'(pwm0);
      c1 += int'(pwm1);
      c2 += int'(pwm2);
      if (pwm0 !== pwm1 || pwm1 !== pwm2) unaligned++;
    end
  endtask

  task automatic test_reset();
    int c0, c1, c2, un;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ea = 3'($urandom);
      eb = 3'($urandom);
      tick(1);
    end
    n_checks++;
    if ({pwm2, pwm1, pwm0} !== 3'b000) $display("FAIL reset_pwm: got %b want 000", {pwm2, pwm1, pwm0});
    else n_pass++;
    n_checks++;
    if (lvl0 !== 8'd0) $display("FAIL reset_level0: got %0d want 0", lvl0); else n_pass++;
    n_checks++;
    if (lvl1 !== 8'd0) $display("FAIL reset_level1: got %0d want 0", lvl1); else n_pass++;
    n_checks++;
    if (lvl2 !== 8'd0) $display("FAIL reset_level2: got %0d want 0", lvl2); else n_pass++;
    ea = 3'b000;
    eb = 3'b000;
    reset = 1'b0;
    measure(512, c0, c1, c2, un);
    n_checks++;
    if (c0 != 0) $display("FAIL post_reset_pwm0: high %0d cycles want 0", c0); else n_pass++;
    n_checks++;
    if (c1 != 0) $display("FAIL post_reset_pwm1: high %0d cycles want 0", c1); else n_pass++;
    n_checks++;
    if (c2 != 0) $display("FAIL post_reset_pwm2: high %0d cycles want 0", c2); else n_pass++;
  endtask

  task automatic test_clockwise();
    int c0, c1, c2, un;
    apply_reset();
    for (int i = 0; i < 10; i++) detent(3'b001, 1'b0);
    n_checks++;
    if (lvl0 !== 8'd10) $display("FAIL cw_level0: got %0d want 10", lvl0); else n_pass++;
    n_checks++;
    if ({lvl2, lvl1} !== 16'd0) $display("FAIL cw_others_level: got %0d/%0d want 0/0", lvl1, lvl2);
    else n_pass++;
    measure(256, c0, c1, c2, un);
    n_checks++;
    if (c0 != 10) $display("FAIL cw_pwm0_duty: high %0d of 256 want 10", c0); else n_pass++;
    n_checks++;
    if (c1 != 0 || c2 != 0) $display("FAIL cw_others_duty: high %0d/%0d want 0/0", c1, c2);
    else n_pass++;
  endtask

  task automatic test_ccw_wrap();
    int c0, c1, c2, un;
    apply_reset();
    detent(3'b010, 1'b1);
    n_checks++;
    if (lvl1 !== 8'd255) $display("FAIL ccw_wrap_level1: got %0d want 255", lvl1); else n_pass++;
    measure(256, c0, c1, c2, un);
    n_checks++;
    if (c1 != 255) $display("FAIL ccw_wrap_pwm1_duty: high %0d of 256 want 255", c1); else n_pass++;
    n_checks++;
    if (c0 != 0 || c2 != 0) $display("FAIL ccw_wrap_others_duty: high %0d/%0d want 0/0", c0, c2);
    else n_pass++;
    detent(3'b010, 1'b0);
    n_checks++;
    if (lvl1 !== 8'd0) $display("FAIL cw_wrap_level1: got %0d want 0", lvl1); else n_pass++;
  endtask

  task automatic test_latency();
    apply_reset();
    ea[2] = 1'b1;
    tick(LAT - 1);
    n_checks++;
    if (lvl2 !== 8'd0) $display("FAIL latency_early: got %0d want 0 at edge %0d", lvl2, LAT - 1);
    else n_pass++;
    tick(1);
    n_checks++;
    if (lvl2 !== 8'd1) $display("FAIL latency_edge: got %0d want 1 at edge %0d", lvl2, LAT);
    else n_pass++;
    ea[2] = 1'b0;
    tick(30);
  endtask

  task automatic test_glitch();
    level_t exp;
    exp = 8'd1;
    // 5- and 7-cycle pulses fall short of the debounce window; 8 cycles is the minimum accepted.
    ea[2] = 1'b1; tick(5); ea[2] = 1'b0; tick(30);
    if (!DEB_ON) exp = exp + 8'd1;
    n_checks++;
    if (lvl2 !== exp) $display("FAIL glitch5_level2: got %0d want %0d", lvl2, exp); else n_pass++;
    ea[2] = 1'b1; tick(7); ea[2] = 1'b0; tick(30);
    if (!DEB_ON) exp = exp + 8'd1;
    n_checks++;
    if (lvl2 !== exp) $display("FAIL glitch7_level2: got %0d want %0d", lvl2, exp); else n_pass++;
    ea[2] = 1'b1; tick(8); ea[2] = 1'b0; tick(30);
    exp = exp + 8'd1;
    n_checks++;
    if (lvl2 !== exp) $display("FAIL pulse8_level2: got %0d want %0d", lvl2, exp); else n_pass++;
  endtask

  task automatic test_simultaneous();
    int c0, c1, c2, un;
    level_t exp;
    apply_reset();
    for (int k = 0; k < 2; k++) begin
      exp = level_t'(k);
      ea = 3'b111;
      tick(LAT - 1);
      n_checks++;
      if ({lvl2, lvl1, lvl0} !== {exp, exp, exp})
        $display("FAIL sim_pre_%0d: got %0d/%0d/%0d want %0d", k, lvl0, lvl1, lvl2, exp);
      else n_pass++;
      tick(1);
      exp = exp + 8'd1;
      n_checks++;
      if ({lvl2, lvl1, lvl0} !== {exp, exp, exp})
        $display("FAIL sim_step_%0d: got %0d/%0d/%0d want %0d", k, lvl0, lvl1, lvl2, exp);
      else n_pass++;
      tick(20 - LAT);
      eb = 3'b111; tick(20);
      ea = 3'b000; tick(20);
      eb = 3'b000; tick(20);
    end
    measure(256, c0, c1, c2, un);
    n_checks++;
    if (c0 != 2 || c1 != 2 || c2 != 2)
      $display("FAIL sim_duty: high %0d/%0d/%0d want 2/2/2", c0, c1, c2);
    else n_pass++;
    n_checks++;
    if (un != 0) $display("FAIL sim_phase_align: %0d unaligned cycles want 0", un); else n_pass++;
    ea = 3'b111;
    tick(LAT);
    reset = 1'b1;
    tick(1);
    n_checks++;
    if ({lvl2, lvl1, lvl0} !== 24'd0)
      $display("FAIL mid_reset_levels: got %0d/%0d/%0d want 0/0/0", lvl0, lvl1, lvl2);
    else n_pass++;
    tick(3);
    n_checks++;
    if ({pwm2, pwm1, pwm0} !== 3'b000) $display("FAIL mid_reset_pwm: got %b want 000", {pwm2, pwm1, pwm0});
    else n_pass++;
    ea = 3'b000;
    reset = 1'b0;
    tick(2);
  endtask

  initial begin
    reset = 1'b1;
    ea = 3'b000;
    eb = 3'b000;
    tick(2);
    test_reset();
    test_clockwise();
    test_ccw_wrap();
    test_latency();
    test_glitch();
    test_simultaneous();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
